// File: rtl/tcp_tx_ctrl_rr.sv
// tcp_tx_ctrl_rr: multi-scheduler TCP TX protocol control FSM.
// Round-robin arbitration over NUM_SCHED scheduler request channels. For each
// granted flow it reads TX state, RX state and the tail pointer, runs calc,
// optionally reads the tuple and emits a packet, writes back TX state, and
// returns the update to the originating scheduler channel.
// Ports:
//   clk, rst                          clock, async active-high reset
//   sched_tx_req_val/tx_sched_req_rdy per-channel flow request handshake
//   sched_tx_update_val/_rdy          per-channel update handshake
//   ctrl_datap_sched_sel              channel index for the datapath muxes
//   *_rd_req_*, *_rd_resp_*           TX state / RX state / tail / tuple reads
//   proto_calc_next_tx_state_wr_req_* TX state writeback
//   ctrl_datap_store_*                datapath register enables
//   datap_ctrl_produce_pkt            calc result: a packet is to be sent
//   proto_calc_tx_pkt_val/_rdy        packet out handshake
//   ctrl_stat_*                       wrapping statistics counters
module tcp_tx_ctrl_rr #(
    parameter int NUM_SCHED     = 4,
    parameter int SKIP_TUPLE_RD = 1,
    parameter int CNT_W         = 32,
    localparam int SEL_W        = (NUM_SCHED > 1) ? $clog2(NUM_SCHED) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SCHED-1:0] sched_tx_req_val,
    output logic [NUM_SCHED-1:0] tx_sched_req_rdy,
    output logic [NUM_SCHED-1:0] sched_tx_update_val,
    input  logic [NUM_SCHED-1:0] sched_tx_update_rdy,
    output logic [SEL_W-1:0]     ctrl_datap_sched_sel,
    output logic                 tx_pipe_tx_tail_ptr_rd_req_val,
    input  logic                 tx_tail_ptr_tx_pipe_rd_req_rdy,
    input  logic                 tx_tail_ptr_tx_pipe_rd_resp_val,
    output logic                 tx_pipe_tx_tail_ptr_rd_resp_rdy,
    output logic                 proto_calc_curr_tx_state_rd_req_val,
    input  logic                 curr_tx_state_proto_calc_rd_req_rdy,
    input  logic                 curr_tx_state_proto_calc_rd_resp_val,
    output logic                 proto_calc_curr_tx_state_rd_resp_rdy,
    output logic                 proto_calc_rx_state_rd_req_val,
    input  logic                 rx_state_proto_calc_rd_req_rdy,
    input  logic                 rx_state_proto_calc_rd_resp_val,
    output logic                 proto_calc_rx_state_rd_resp_rdy,
    output logic                 proto_calc_tuple_rd_req_val,
    input  logic                 tuple_proto_calc_rd_req_rdy,
    input  logic                 tuple_proto_calc_rd_resp_val,
    output logic                 proto_calc_tuple_rd_resp_rdy,
    output logic                 proto_calc_next_tx_state_wr_req_val,
    input  logic                 next_tx_state_proto_calc_wr_req_rdy,
    output logic                 ctrl_datap_store_flowid,
    output logic                 ctrl_datap_store_state,
    output logic                 ctrl_datap_store_calc,
    output logic                 ctrl_datap_store_tuple,
    input  logic                 datap_ctrl_produce_pkt,
    output logic                 proto_calc_tx_pkt_val,
    input  logic                 proto_calc_tx_pkt_rdy,
    output logic [CNT_W-1:0]     ctrl_stat_pkts_sent,
    output logic [CNT_W-1:0]     ctrl_stat_flows_serviced
);

    localparam int unsigned NS = NUM_SCHED;

    typedef enum logic [3:0] {
        ARB, RD_STATE, WAIT_STATE, CALC, DECIDE,
        RD_TUPLE, WAIT_TUPLE, PKT_OUT, WRITEBACK, SCHED_UPDATE
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] chan_reg;
    logic [2:0]       acc;      // {tail, rx, tx} read requests already accepted

    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     cand;
    logic [SEL_W-1:0]     nxt_ptr;
    logic                 any_req;
    logic [NUM_SCHED-1:0] grant_oh;
    logic [NUM_SCHED-1:0] chan_oh;
    logic [2:0]           rd_rdy;
    logic [2:0]           rd_hs;
    logic                 rd_done;
    logic                 resp_all;

    // First requesting channel at or after rr_ptr, wrapping modulo NUM_SCHED.
    always_comb begin
        grant   = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            cand = SEL_W'((32'(rr_ptr) + i) % NS);
            if (!any_req && sched_tx_req_val[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
        nxt_ptr     = SEL_W'((32'(grant) + 32'd1) % NS);
        grant_oh    = '0;
        grant_oh[grant] = 1'b1;
        chan_oh     = '0;
        chan_oh[chan_reg] = 1'b1;
    end

    assign rd_rdy   = {tx_tail_ptr_tx_pipe_rd_req_rdy,
                       rx_state_proto_calc_rd_req_rdy,
                       curr_tx_state_proto_calc_rd_req_rdy};
    assign rd_hs    = ~acc & rd_rdy;
    assign rd_done  = &(acc | rd_hs);
    assign resp_all = tx_tail_ptr_tx_pipe_rd_resp_val &
                      rx_state_proto_calc_rd_resp_val &
                      curr_tx_state_proto_calc_rd_resp_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= ARB;
            rr_ptr                   <= '0;
            chan_reg                 <= '0;
            acc                      <= '0;
            ctrl_stat_pkts_sent      <= '0;
            ctrl_stat_flows_serviced <= '0;
        end else begin
            case (state)
                ARB: if (any_req) begin
                    chan_reg <= grant;
                    rr_ptr   <= nxt_ptr;
                    state    <= RD_STATE;
                end
                RD_STATE: begin
                    if (rd_done) begin
                        acc   <= '0;
                        state <= WAIT_STATE;
                    end else begin
                        acc <= acc | rd_hs;
                    end
                end
                WAIT_STATE: if (resp_all) state <= CALC;
                CALC:       state <= DECIDE;
                DECIDE:     state <= (datap_ctrl_produce_pkt || SKIP_TUPLE_RD == 0)
                                     ? RD_TUPLE : WRITEBACK;
                RD_TUPLE:   if (tuple_proto_calc_rd_req_rdy) state <= WAIT_TUPLE;
                WAIT_TUPLE: if (tuple_proto_calc_rd_resp_val)
                                state <= datap_ctrl_produce_pkt ? PKT_OUT : WRITEBACK;
                PKT_OUT: if (proto_calc_tx_pkt_rdy) begin
                    ctrl_stat_pkts_sent <= ctrl_stat_pkts_sent + CNT_W'(1);
                    state               <= WRITEBACK;
                end
                WRITEBACK: if (next_tx_state_proto_calc_wr_req_rdy) state <= SCHED_UPDATE;
                SCHED_UPDATE: if (sched_tx_update_rdy[chan_reg]) begin
                    ctrl_stat_flows_serviced <= ctrl_stat_flows_serviced + CNT_W'(1);
                    state                    <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    // Handshake outputs are decoded from the registered state so that ready
    // and valid land in the same cycle as the partner's signal; rst forces
    // every output low without waiting for a clock.
    always_comb begin
        tx_sched_req_rdy                     = '0;
        sched_tx_update_val                  = '0;
        ctrl_datap_sched_sel                 = '0;
        tx_pipe_tx_tail_ptr_rd_req_val       = 1'b0;
        tx_pipe_tx_tail_ptr_rd_resp_rdy      = 1'b0;
        proto_calc_curr_tx_state_rd_req_val  = 1'b0;
        proto_calc_curr_tx_state_rd_resp_rdy = 1'b0;
        proto_calc_rx_state_rd_req_val       = 1'b0;
        proto_calc_rx_state_rd_resp_rdy      = 1'b0;
        proto_calc_tuple_rd_req_val          = 1'b0;
        proto_calc_tuple_rd_resp_rdy         = 1'b0;
        proto_calc_next_tx_state_wr_req_val  = 1'b0;
        ctrl_datap_store_flowid              = 1'b0;
        ctrl_datap_store_state               = 1'b0;
        ctrl_datap_store_calc                = 1'b0;
        ctrl_datap_store_tuple               = 1'b0;
        proto_calc_tx_pkt_val                = 1'b0;
        if (!rst) begin
            ctrl_datap_sched_sel = (state == ARB) ? grant : chan_reg;
            case (state)
                ARB: begin
                    tx_sched_req_rdy        = any_req ? grant_oh : '0;
                    ctrl_datap_store_flowid = 1'b1;
                end
                RD_STATE: begin
                    proto_calc_curr_tx_state_rd_req_val = ~acc[0];
                    proto_calc_rx_state_rd_req_val      = ~acc[1];
                    tx_pipe_tx_tail_ptr_rd_req_val      = ~acc[2];
                end
                WAIT_STATE: begin
                    proto_calc_curr_tx_state_rd_resp_rdy = resp_all;
                    proto_calc_rx_state_rd_resp_rdy      = resp_all;
                    tx_pipe_tx_tail_ptr_rd_resp_rdy      = resp_all;
                    ctrl_datap_store_state               = resp_all;
                end
                CALC:         ctrl_datap_store_calc = 1'b1;
                RD_TUPLE:     proto_calc_tuple_rd_req_val = 1'b1;
                WAIT_TUPLE: begin
                    proto_calc_tuple_rd_resp_rdy = 1'b1;
                    ctrl_datap_store_tuple       = tuple_proto_calc_rd_resp_val;
                end
                PKT_OUT:      proto_calc_tx_pkt_val = 1'b1;
                WRITEBACK:    proto_calc_next_tx_state_wr_req_val = 1'b1;
                SCHED_UPDATE: sched_tx_update_val = chan_oh;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tcp_tx_ctrl_rr.md
Name: tcp_tx_ctrl_rr

Overview:
Multi-scheduler TCP TX protocol control FSM, the parametrised successor of the single-scheduler TX controller.
- Arbitrates NUM_SCHED scheduler request channels round-robin and services one flow at a time: reads TX state, RX state and tail pointer; runs calc; optionally reads the tuple and emits a packet; writes back TX state; returns the update to the originating scheduler channel.
- Sits between the TX schedulers and the TX state/tuple memories; drives store strobes into the TX datapath.
- Adds per-request accept tracking, a tuple-read-skip mode and statistics counters.

Parameters:
NUM_SCHED, 4, number of scheduler request/update channel pairs (>=1)
SKIP_TUPLE_RD, 1, 1: read the tuple only when a packet will be produced; 0: always read the tuple
CNT_W, 32, width of the statistics counters
(localparam SEL_W = max(1, clog2(NUM_SCHED)))

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
sched_tx_req_val  in  NUM_SCHED  per-channel flow request valid
tx_sched_req_rdy  out  NUM_SCHED  per-channel request ready; one-hot or zero
sched_tx_update_val  out  NUM_SCHED  per-channel update valid; one-hot or zero
sched_tx_update_rdy  in  NUM_SCHED  per-channel update ready
ctrl_datap_sched_sel  out  SEL_W  channel index the datapath muxes the flowid/update from
tx_pipe_tx_tail_ptr_rd_req_val / tx_tail_ptr_tx_pipe_rd_req_rdy  out/in  1  tail pointer read request
tx_tail_ptr_tx_pipe_rd_resp_val / tx_pipe_tx_tail_ptr_rd_resp_rdy  in/out  1  tail pointer read response
proto_calc_curr_tx_state_rd_req_val / _rd_req_rdy  out/in  1  TX state read request
proto_calc_curr_tx_state_rd_resp_val / _rd_resp_rdy  in/out  1  TX state read response
proto_calc_rx_state_rd_req_val / rx_state_proto_calc_rd_req_rdy  out/in  1  RX state read request
rx_state_proto_calc_rd_resp_val / proto_calc_rx_state_rd_resp_rdy  in/out  1  RX state read response
proto_calc_tuple_rd_req_val / tuple_proto_calc_rd_req_rdy  out/in  1  tuple read request
tuple_proto_calc_rd_resp_val / proto_calc_tuple_rd_resp_rdy  in/out  1  tuple read response
proto_calc_next_tx_state_wr_req_val / _wr_req_rdy  out/in  1  TX state writeback
ctrl_datap_store_flowid, _store_state, _store_calc, _store_tuple  out  1 each  datapath register enables
datap_ctrl_produce_pkt  in  1  calc result: packet to send; stable from DECIDE through WRITEBACK
proto_calc_tx_pkt_val / proto_calc_tx_pkt_rdy  out/in  1  packet out handshake
ctrl_stat_pkts_sent  out  CNT_W  packets emitted
ctrl_stat_flows_serviced  out  CNT_W  completed scheduler updates

Behaviour:
- Reset: state=ARB, rr_ptr=0, chan_reg=0, accept bits=0, counters=0. Every output is 0 whenever rst is asserted. Reset mid-operation abandons the flow with no cleanup; memories and schedulers reset together.
- All outputs not listed for a state are 0. States use a 4-bit encoding.
- ARB: grant = first index with req_val set, searching from rr_ptr upward modulo NUM_SCHED. tx_sched_req_rdy[grant]=1; store_flowid=1; sched_sel=grant. If any req_val: chan_reg<=grant, rr_ptr<=(grant+1) mod NUM_SCHED, go to RD_STATE. If no req_val: rdy=0, stay in ARB.
- RD_STATE: assert each of the three read-request vals (TX state, RX state, tail pointer) while its accept bit is 0. Set an accept bit on its val&rdy. Exit to WAIT_STATE once all three are accepted (this cycle or earlier); clear the accept bits on exit. Requests may be accepted in different cycles; no request is ever issued twice.
- WAIT_STATE: join the three responses. When all three resp_val are high: assert all three resp_rdy and store_state=1, go to CALC. Otherwise all three resp_rdy=0.
- CALC: store_calc=1 for one cycle; go to DECIDE.
- DECIDE: if produce_pkt or SKIP_TUPLE_RD==0, go to RD_TUPLE; else go to WRITEBACK.
- RD_TUPLE: tuple req_val=1 until rdy; then go to WAIT_TUPLE.
- WAIT_TUPLE: resp_rdy=1; store_tuple=resp_val. On resp_val: go to PKT_OUT if produce_pkt, else WRITEBACK.
- PKT_OUT: tx_pkt_val=1 held until rdy; on handshake, pkts_sent+=1, go to WRITEBACK.
- WRITEBACK: wr_req_val=1 until rdy; then go to SCHED_UPDATE.
- SCHED_UPDATE: sched_tx_update_val[chan_reg]=1, sched_sel=chan_reg. On sched_tx_update_rdy[chan_reg]: flows_serviced+=1, go to ARB. Ready on any other channel is ignored.
- sched_sel equals chan_reg in all states except ARB.
- Counters wrap modulo 2^CNT_W.
- Minimum latency with all responders immediate: 7 cycles ARB-to-ARB without a packet, 10 with a packet.
- NUM_SCHED=1: arbiter degenerates; sel is constant 0.

Test Plan:
- Single flow, channel 0, produce_pkt=1, all rdy/resp immediate -> ARB→...→ARB in 10 cycles; pkts_sent=1, flows_serviced=1, update_val=4'b0001.
- Channels 0,2,3 requesting continuously, rr_ptr=0 -> grants in order 0,2,3,0; update_val one-hot matches each grant.
- Staggered accepts in RD_STATE (TX state rdy cycle 1, RX cycle 3, tail cycle 5) -> each val drops after its accept; exactly one request per memory; exit after cycle 5.
- produce_pkt=0, SKIP_TUPLE_RD=1 -> no tuple req, no tx_pkt_val, 7-cycle loop; SKIP_TUPLE_RD=0 -> tuple read occurs, no packet, pkts_sent unchanged.
- tx_pkt_rdy held low 20 cycles -> tx_pkt_val held high 20 cycles, no writeback request until the handshake completes.
- rst asserted asynchronously in WAIT_TUPLE -> all outputs 0 immediately; after release, state=ARB, counters=0, next grant uses rr_ptr=0.
